// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-wide memory controller.
package mem_ctrl_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Which requester owns the current transaction
    typedef enum logic {
        SRC_IF  = 1'b0,
        SRC_LSB = 1'b1
    } src_t;

    // LSB_len codes
    localparam logic [1:0] LEN_BYTE = 2'd1;
    localparam logic [1:0] LEN_HALF = 2'd2;
    localparam logic [1:0] LEN_WORD = 2'd3;

    // addr[17:16] value selecting the IO region
    localparam logic [1:0] IO_HI_DEF = 2'b11;

    // Byte count for an LSB_len code; the unused code 0 is treated as a byte access
    function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
        logic [2:0] n;
        case (len)
            LEN_HALF: n = 3'd2;
            LEN_WORD: n = 3'd4;
            default:  n = 3'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory controller: serialises 4-byte instruction fetches and 1/2/4-byte
// LSB loads/stores onto a byte-wide RAM/IO bus, one transaction at a time.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = IO_HI_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full,
    input  logic              jump_wrong_stall,
    input  logic              IF_req,
    input  logic [ADDR_W-1:0] IF_addr,
    output logic              IF_flag,
    output logic [31:0]       IF_inst,
    input  logic              LSB_req,
    input  logic              LSB_we,
    input  logic [ADDR_W-1:0] LSB_addr,
    input  logic [1:0]        LSB_len,
    input  logic [31:0]       LSB_wdata,
    output logic              LSB_flag,
    output logic [31:0]       LSB_rdata
);

    state_t            state_q, state_d;
    src_t              src_q, src_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        nbytes_q, nbytes_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       buf_q, buf_d;
    logic              if_flag_q, if_flag_d;
    logic              lsb_flag_q, lsb_flag_d;
    logic [31:0]       if_inst_q, if_inst_d;
    logic [31:0]       lsb_rdata_q, lsb_rdata_d;

    logic [1:0]        cap_idx;
    logic [31:0]       merged;
    logic [ADDR_W-1:0] addr_cnt;
    logic              wr_stall;

    // State and data registers; rdy low freezes everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            src_q       <= SRC_IF;
            addr_q      <= '0;
            nbytes_q    <= '0;
            cnt_q       <= '0;
            wdata_q     <= '0;
            buf_q       <= '0;
            if_flag_q   <= 1'b0;
            lsb_flag_q  <= 1'b0;
            if_inst_q   <= '0;
            lsb_rdata_q <= '0;
        end else if (rdy) begin
            state_q     <= state_d;
            src_q       <= src_d;
            addr_q      <= addr_d;
            nbytes_q    <= nbytes_d;
            cnt_q       <= cnt_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            if_flag_q   <= if_flag_d;
            lsb_flag_q  <= lsb_flag_d;
            if_inst_q   <= if_inst_d;
            lsb_rdata_q <= lsb_rdata_d;
        end
    end

    // Next-state logic plus combinational bus drive (no extra cycle per byte)
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        addr_d      = addr_q;
        nbytes_d    = nbytes_q;
        cnt_d       = cnt_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        if_flag_d   = 1'b0;
        lsb_flag_d  = 1'b0;
        if_inst_d   = if_inst_q;
        lsb_rdata_d = lsb_rdata_q;
        mem_a       = '0;
        mem_dout    = '0;
        mem_wr      = 1'b0;

        addr_cnt = addr_q + ADDR_W'(cnt_q);
        wr_stall = (addr_q[17:16] == IO_HI) && io_buffer_full;
        // The byte on mem_din belongs to the address issued one cycle earlier
        cap_idx  = cnt_q[1:0] - 2'd1;
        merged   = buf_q;
        merged[{cap_idx, 3'b000} +: 8] = mem_din;

        case (state_q)
            ST_IDLE: begin
                if (!jump_wrong_stall) begin
                    if (LSB_req) begin
                        src_d    = SRC_LSB;
                        addr_d   = LSB_addr;
                        nbytes_d = len_to_bytes(LSB_len);
                        wdata_d  = LSB_wdata;
                        buf_d    = '0;
                        cnt_d    = '0;
                        state_d  = LSB_we ? ST_WR : ST_RD;
                    end else if (IF_req) begin
                        src_d    = SRC_IF;
                        addr_d   = IF_addr;
                        nbytes_d = 3'd4;
                        wdata_d  = '0;
                        buf_d    = '0;
                        cnt_d    = '0;
                        state_d  = ST_RD;
                    end
                end
            end

            ST_RD: begin
                if (cnt_q < nbytes_q) begin
                    mem_a = addr_cnt;
                end
                if (jump_wrong_stall) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    if (cnt_q != 3'd0) begin
                        buf_d = merged;
                    end
                    if (cnt_q == nbytes_q) begin
                        state_d = ST_DONE;
                        if (src_q == SRC_IF) begin
                            if_flag_d = 1'b1;
                            if_inst_d = merged;
                        end else begin
                            lsb_flag_d  = 1'b1;
                            lsb_rdata_d = merged;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            ST_WR: begin
                mem_a    = addr_cnt;
                mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                mem_wr   = rdy && !wr_stall;
                if (!wr_stall) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == nbytes_q - 3'd1) begin
                        state_d    = ST_DONE;
                        lsb_flag_d = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign IF_flag   = if_flag_q && rdy;
    assign LSB_flag  = lsb_flag_q && rdy;
    assign IF_inst   = if_inst_q;
    assign LSB_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: table-driven LSB transactions plus hand-written
// sequences for fetch timing, arbitration, IO stall, flush, rdy and reset.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        jump_wrong_stall;
    logic        IF_req;
    logic [31:0] IF_addr;
    logic        IF_flag;
    logic [31:0] IF_inst;
    logic        LSB_req;
    logic        LSB_we;
    logic [31:0] LSB_addr;
    logic [1:0]  LSB_len;
    logic [31:0] LSB_wdata;
    logic        LSB_flag;
    logic [31:0] LSB_rdata;

    int errors = 0;
    int checks = 0;

    mem_ctrl #(.ADDR_W(32), .IO_HI(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full), .jump_wrong_stall(jump_wrong_stall),
        .IF_req(IF_req), .IF_addr(IF_addr), .IF_flag(IF_flag), .IF_inst(IF_inst),
        .LSB_req(LSB_req), .LSB_we(LSB_we), .LSB_addr(LSB_addr), .LSB_len(LSB_len),
        .LSB_wdata(LSB_wdata), .LSB_flag(LSB_flag), .LSB_rdata(LSB_rdata)
    );

    always #5 clk = ~clk;

    // Byte RAM model: registered read, write on mem_wr; aliased to 256 KiB
    logic [7:0] ram [0:262143];
    logic       do_preload = 1'b0;
    int         wr_count = 0;

    always @(posedge clk) begin
        if (do_preload) begin
            for (int unsigned i = 0; i < 262144; i++) ram[i] <= 8'h00;
            ram[18'h00100] <= 8'h13; ram[18'h00101] <= 8'h05;
            ram[18'h00102] <= 8'hA0; ram[18'h00103] <= 8'h00;
            ram[18'h00104] <= 8'h93; ram[18'h00105] <= 8'h00;
            ram[18'h00106] <= 8'h10; ram[18'h00107] <= 8'h00;
            ram[18'h001FF] <= 8'h34; ram[18'h00200] <= 8'h12;
            ram[18'h00201] <= 8'h56; ram[18'h00202] <= 8'h78;
            ram[18'h00203] <= 8'h9A;
            ram[18'h3FFFE] <= 8'h11; ram[18'h3FFFF] <= 8'h22;
            ram[18'h00000] <= 8'h33; ram[18'h00001] <= 8'h44;
            mem_din <= 8'h00;
        end else begin
            mem_din <= ram[mem_a[17:0]];
            if (mem_wr) begin
                ram[mem_a[17:0]] <= mem_dout;
                wr_count <= wr_count + 1;
            end
        end
    end

    // Flag pulse bookkeeping
    int if_pulses = 0;
    int lsb_pulses = 0;
    int overlap = 0;
    always @(negedge clk) begin
        if (IF_flag) if_pulses <= if_pulses + 1;
        if (LSB_flag) lsb_pulses <= lsb_pulses + 1;
        if (IF_flag && LSB_flag) overlap <= overlap + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Wait up to max_cyc edges for a flag; k counts edges from the first one
    task automatic wait_flag(input bit want_if, input int max_cyc, output int lat, output bit seen);
        seen = 1'b0;
        lat  = -1;
        for (int k = 0; k < max_cyc; k++) begin
            @(posedge clk); #1;
            if (want_if ? IF_flag : LSB_flag) begin
                lat  = k;
                seen = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int  lat;
        bit  seen;
        int  wc;
        int  pc;

        vecs[0]  = '{1'b1, 32'h0000_1000, 2'd3, 32'hDEAD_BEEF, 32'h0,           4};
        vecs[1]  = '{1'b0, 32'h0000_1000, 2'd3, 32'h0,         32'hDEAD_BEEF,   5};
        vecs[2]  = '{1'b0, 32'h0000_1001, 2'd1, 32'h0,         32'h0000_00BE,   2};
        vecs[3]  = '{1'b0, 32'h0000_1002, 2'd2, 32'h0,         32'h0000_DEAD,   3};
        vecs[4]  = '{1'b1, 32'h0000_1005, 2'd2, 32'h1234_ABCD, 32'h0,           2};
        vecs[5]  = '{1'b0, 32'h0000_1004, 2'd3, 32'h0,         32'h00AB_CD00,   5};
        vecs[6]  = '{1'b1, 32'h0000_1007, 2'd1, 32'hFFFF_FF77, 32'h0,           1};
        vecs[7]  = '{1'b0, 32'h0000_1004, 2'd3, 32'h0,         32'h77AB_CD00,   5};
        vecs[8]  = '{1'b0, 32'h0000_01FF, 2'd2, 32'h0,         32'h0000_1234,   3};
        vecs[9]  = '{1'b0, 32'hFFFF_FFFE, 2'd3, 32'h0,         32'h4433_2211,   5};
        vecs[10] = '{1'b0, 32'h0003_FFFF, 2'd1, 32'h0,         32'h0000_0022,   2};

        rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; jump_wrong_stall = 1'b0;
        IF_req = 1'b0; IF_addr = '0; LSB_req = 1'b0; LSB_we = 1'b0;
        LSB_addr = '0; LSB_len = 2'd0; LSB_wdata = '0;
        do_preload = 1'b1;
        @(posedge clk); #1;
        do_preload = 1'b0;
        @(posedge clk); #1;

        // Reset values
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
        chk("rst_mem_dout", {24'b0, mem_dout}, 32'h0);
        chk("rst_if_flag", {31'b0, IF_flag}, 32'h0);
        chk("rst_lsb_flag", {31'b0, LSB_flag}, 32'h0);
        chk("rst_if_inst", IF_inst, 32'h0);
        chk("rst_lsb_rdata", LSB_rdata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Instruction fetch: consecutive byte addresses, flag after 5th edge
        IF_addr = 32'h100; IF_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk($sformatf("if_mem_a_%0d", i), mem_a, (i < 4) ? 32'h100 + 32'(i) : 32'h0);
            chk($sformatf("if_flag_%0d", i), {31'b0, IF_flag}, (i == 5) ? 32'h1 : 32'h0);
        end
        chk("if_inst", IF_inst, 32'h00A0_0513);
        IF_req = 1'b0;
        @(posedge clk); #1;
        chk("if_flag_drop", {31'b0, IF_flag}, 32'h0);
        chk("if_mem_wr", {31'b0, mem_wr}, 32'h0);

        // Table of LSB transactions
        foreach (vecs[v]) begin
            LSB_we = vecs[v].we; LSB_addr = vecs[v].addr; LSB_len = vecs[v].len;
            LSB_wdata = vecs[v].wdata; LSB_req = 1'b1;
            wait_flag(1'b0, 20, lat, seen);
            chk($sformatf("vec%0d_seen", v), {31'b0, seen}, 32'h1);
            chk($sformatf("vec%0d_lat", v), lat, vecs[v].exp_lat);
            if (!vecs[v].we)
                chk($sformatf("vec%0d_rdata", v), LSB_rdata, vecs[v].exp_rdata);
            LSB_req = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_pulse", v), {31'b0, LSB_flag}, 32'h0);
        end

        // Simultaneous requests: LSB first, then fetch after DONE/IDLE
        pc = if_pulses;
        IF_addr = 32'h100; IF_req = 1'b1;
        LSB_we = 1'b0; LSB_addr = 32'h200; LSB_len = 2'd3; LSB_req = 1'b1;
        wait_flag(1'b0, 20, lat, seen);
        chk("arb_lsb_seen", {31'b0, seen}, 32'h1);
        chk("arb_lsb_rdata", LSB_rdata, 32'h9A78_5612);
        chk("arb_if_not_first", if_pulses, pc);
        LSB_req = 1'b0;
        wait_flag(1'b1, 20, lat, seen);
        chk("arb_if_seen", {31'b0, seen}, 32'h1);
        chk("arb_if_lat", lat, 6);
        chk("arb_if_inst", IF_inst, 32'h00A0_0513);
        IF_req = 1'b0;
        @(posedge clk); #1;

        // IO-region store stalled by a full buffer for three cycles
        wc = wr_count;
        LSB_we = 1'b1; LSB_addr = 32'h0003_0000; LSB_len = 2'd1;
        LSB_wdata = 32'h0000_0041; LSB_req = 1'b1; io_buffer_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("io_stall_wr_%0d", i), {31'b0, mem_wr}, 32'h0);
        end
        chk("io_no_write", wr_count, wc);
        io_buffer_full = 1'b0; #1;
        chk("io_wr", {31'b0, mem_wr}, 32'h1);
        chk("io_a", mem_a, 32'h0003_0000);
        chk("io_dout", {24'b0, mem_dout}, 32'h41);
        @(posedge clk); #1;
        chk("io_flag", {31'b0, LSB_flag}, 32'h1);
        chk("io_one_write", wr_count - wc, 1);
        chk("io_ram", {24'b0, ram[18'h30000]}, 32'h41);
        LSB_req = 1'b0;
        @(posedge clk); #1;

        // Flush two cycles into a fetch, then new address on following edge
        pc = if_pulses;
        IF_addr = 32'h100; IF_req = 1'b1;
        @(posedge clk); #1;
        chk("jw_a0", mem_a, 32'h100);
        @(posedge clk); #1;
        chk("jw_a1", mem_a, 32'h101);
        jump_wrong_stall = 1'b1;
        @(posedge clk); #1;
        chk("jw_idle_a", mem_a, 32'h0);
        chk("jw_no_flag", {31'b0, IF_flag}, 32'h0);
        jump_wrong_stall = 1'b0; IF_addr = 32'h104;
        @(posedge clk); #1;
        chk("jw_new_a", mem_a, 32'h104);
        wait_flag(1'b1, 20, lat, seen);
        chk("jw_lat", lat, 4);
        chk("jw_inst", IF_inst, 32'h0010_0093);
        IF_req = 1'b0;
        @(posedge clk); #1;
        chk("jw_one_pulse", if_pulses - pc, 1);

        // Flush while idle blocks acceptance for that edge
        IF_addr = 32'h100; IF_req = 1'b1; jump_wrong_stall = 1'b1;
        @(posedge clk); #1;
        chk("jw_idle_block", mem_a, 32'h0);
        jump_wrong_stall = 1'b0;
        @(posedge clk); #1;
        chk("jw_idle_accept", mem_a, 32'h100);
        wait_flag(1'b1, 20, lat, seen);
        chk("jw_idle_lat", lat, 4);
        chk("jw_idle_inst", IF_inst, 32'h00A0_0513);
        IF_req = 1'b0;
        @(posedge clk); #1;

        // rdy low freezes a store
        LSB_we = 1'b1; LSB_addr = 32'h1010; LSB_len = 2'd1;
        LSB_wdata = 32'h0000_005A; LSB_req = 1'b1;
        @(posedge clk); #1;
        rdy = 1'b0; #1;
        chk("rdy_wr_forced", {31'b0, mem_wr}, 32'h0);
        wc = wr_count;
        repeat (2) @(posedge clk);
        #1;
        chk("rdy_no_write", wr_count, wc);
        chk("rdy_no_flag", {31'b0, LSB_flag}, 32'h0);
        rdy = 1'b1;
        wait_flag(1'b0, 10, lat, seen);
        chk("rdy_lat", lat, 0);
        chk("rdy_ram", {24'b0, ram[18'h01010]}, 32'h5A);
        LSB_req = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a word store after two bytes
        wc = wr_count;
        LSB_we = 1'b1; LSB_addr = 32'h2000; LSB_len = 2'd3;
        LSB_wdata = 32'hCAFE_F00D; LSB_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_writes", wr_count - wc, 2);
        rst = 1'b1; LSB_req = 1'b0; #1;
        chk("rst_mid_a", mem_a, 32'h0);
        chk("rst_mid_wr", {31'b0, mem_wr}, 32'h0);
        chk("rst_mid_dout", {24'b0, mem_dout}, 32'h0);
        chk("rst_mid_flag", {31'b0, LSB_flag}, 32'h0);
        chk("rst_mid_ram0", {24'b0, ram[18'h02000]}, 32'h0D);
        chk("rst_mid_ram1", {24'b0, ram[18'h02001]}, 32'hF0);
        chk("rst_mid_ram2", {24'b0, ram[18'h02002]}, 32'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        pc = lsb_pulses;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_mid_no_pulse", lsb_pulses, pc);
        chk("rst_mid_idle_a", mem_a, 32'h0);

        chk("flag_overlap", overlap, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
